// File: rtl/led7seg_scan.sv
// Four-digit multiplexed common-anode 7-segment driver: shows a 16-bit value as hex,
// lighting one digit at a time for 2**SCAN_BITS clocks each, with registered active-low outputs.
module led7seg_scan #(
    parameter int SCAN_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data,
    output logic [7:0]  seg,
    output logic [3:0]  segsel
);

    logic [SCAN_BITS-1:0] r_cnt;
    logic [1:0]           r_idx;
    logic [7:0]           r_seg;
    logic [3:0]           r_segsel;
    logic [3:0]           w_nibble;
    logic [6:0]           w_pat;

    // data is deliberately not latched, so a change shows up on the very next edge
    assign w_nibble = data[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_pat = 7'h00;
        case (w_nibble)
            4'h0: w_pat = 7'h3F;
            4'h1: w_pat = 7'h06;
            4'h2: w_pat = 7'h5B;
            4'h3: w_pat = 7'h4F;
            4'h4: w_pat = 7'h66;
            4'h5: w_pat = 7'h6D;
            4'h6: w_pat = 7'h7D;
            4'h7: w_pat = 7'h07;
            4'h8: w_pat = 7'h7F;
            4'h9: w_pat = 7'h6F;
            4'hA: w_pat = 7'h77;
            4'hB: w_pat = 7'h7C;
            4'hC: w_pat = 7'h39;
            4'hD: w_pat = 7'h5E;
            4'hE: w_pat = 7'h79;
            default: w_pat = 7'h71;
        endcase
    end

    // Outputs reflect the digit index held before this edge's advance, giving one cycle of latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_idx    <= 2'd0;
            r_seg    <= 8'hFF;
            r_segsel <= 4'hF;
        end else begin
            r_cnt <= r_cnt + {{(SCAN_BITS-1){1'b0}}, 1'b1};
            if (r_cnt == {SCAN_BITS{1'b1}}) begin
                r_idx <= r_idx + 2'd1;
            end
            r_segsel <= ~(4'b0001 << r_idx);
            r_seg    <= {1'b1, ~w_pat};
        end
    end

    assign seg    = r_seg;
    assign segsel = r_segsel;

endmodule

// File: tb/tb_led7seg_scan.sv
// Self-checking bench for led7seg_scan (SCAN_BITS=2): an edge-counting display model checked
// every negedge, plus hand-computed literal expectations for the directed scenarios.
module tb_led7seg_scan;

    logic        clk;
    logic        reset;
    logic [15:0] data;
    logic [7:0]  seg;
    logic [3:0]  segsel;

    int passCount  = 0;
    int checkCount = 0;
    bit compareEn  = 1'b0;

    logic [6:0] patTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int         edgesSinceReset = 0;
    logic [7:0] expSeg = 8'hFF;
    logic [3:0] expSel = 4'hF;

    led7seg_scan #(.SCAN_BITS(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .data   (data),
        .seg    (seg),
        .segsel (segsel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the n-th edge after reset release shows digit ((n-1)/4)%4 of the data present at that edge
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            edgesSinceReset = 0;
            expSeg = 8'hFF;
            expSel = 4'hF;
        end else begin
            int digit;
            digit  = (edgesSinceReset / 4) % 4;
            expSel = ~(4'(1) << digit);
            expSeg = {1'b1, ~patTable[(data >> (4 * digit)) & 16'hF]};
            edgesSinceReset++;
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] required);
        checkCount++;
        if (actual === required) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, required, $time);
        end
    endtask

    always @(negedge clk) begin
        if (compareEn) begin
            checkOutput("model seg", seg, expSeg);
            checkOutput("model segsel", {4'h0, segsel}, {4'h0, expSel});
            if (edgesSinceReset > 0) begin
                checkOutput("onehot low", {7'h0, $countones(~segsel) == 1}, 8'h01);
            end
        end
    end

    // Resets the scan so the next posedge is the first edge showing digit 0
    task automatic applyStimulus(input logic [15:0] value);
        @(negedge clk);
        #1;
        reset = 1'b0;
        data  = value;
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    logic [3:0] selLit [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] seg1234 [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] seg08AF [4] = '{8'h8E, 8'h88, 8'h80, 8'hC0};

    initial begin
        reset = 1'b0;
        data  = 16'h1234;
        compareEn = 1'b1;

        // Held in reset with clock running
        repeat (6) @(posedge clk);
        #1;
        checkOutput("reset seg", seg, 8'hFF);
        checkOutput("reset segsel", {4'h0, segsel}, 8'h0F);

        // Scan of 1234 through a full rotation and back to digit 0
        applyStimulus(16'h1234);
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            checkOutput("scan1234 segsel", {4'h0, segsel}, {4'h0, selLit[(i / 4) % 4]});
            checkOutput("scan1234 seg", seg, seg1234[(i / 4) % 4]);
        end

        applyStimulus(16'h08AF);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (i % 4 == 0) begin
                checkOutput("scan08AF seg", seg, seg08AF[i / 4]);
                checkOutput("scan08AF segsel", {4'h0, segsel}, {4'h0, selLit[i / 4]});
            end
        end

        // Repeated-nibble sweep; the model covers every digit of every value
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            #1;
            data = {4'(n), 4'(n), 4'(n), 4'(n)};
            repeat (16) @(posedge clk);
        end
        #1;
        checkOutput("sweep F seg", seg, 8'h8E);

        // Mid-dwell data change on digit 0
        applyStimulus(16'h1234);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        data = 16'h123F;
        @(posedge clk);
        #1;
        checkOutput("live update seg", seg, 8'h8E);
        checkOutput("live update segsel", {4'h0, segsel}, 8'h0E);

        // Reset pulse between edges while digit 2 is lit
        applyStimulus(16'h1234);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("pre-pulse segsel", {4'h0, segsel}, 8'h0B);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("pulse seg", seg, 8'hFF);
        checkOutput("pulse segsel", {4'h0, segsel}, 8'h0F);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("restart segsel", {4'h0, segsel}, {4'h0, selLit[i / 4]});
        end

        @(negedge clk);
        compareEn = 1'b0;
        #1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
